// File: rtl/load_unit.sv
// Single-outstanding load: IDLE->REQ->WAIT->DONE, start-to-done 3 cycles minimum; faults finish in 1.
// Waits on mem_ready/mem_rvalid and ignores start while busy. LOAD_TIMEOUT_EN adds a TIMEOUT-cycle abort.
module load_unit
`ifdef LOAD_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT = 16
)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  type_,
   input  logic        unsigned_,
   input  logic [31:0] addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] rd_data,
   output logic        fault,
   output logic        timeout,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  type_q, type_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        fault_q, fault_d;
   logic        timeout_q, timeout_d;

   logic        misaligned;
   logic        expired;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;

   assign misaligned = (type_ == 2'b11)
                     | ((type_ == 2'b01) & addr[0])
                     | ((type_ == 2'b10) & (addr[1:0] != 2'b00));

`ifdef LOAD_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Only IDLE leads into REQ, so clearing in IDLE is the same as clearing on REQ entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE) begin
         cnt_d = '0;
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      case (off_q)
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         2'd3:    byte_lane = mem_rdata[31:24];
         default: byte_lane = mem_rdata[7:0];
      endcase
      half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (type_q)
         2'b00:   load_data = {{24{byte_lane[7] & ~unsigned_q}}, byte_lane};
         2'b01:   load_data = {{16{half_lane[15] & ~unsigned_q}}, half_lane};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      unsigned_d = unsigned_q;
      off_d      = off_q;
      mem_addr_d = mem_addr_q;
      rd_data_d  = rd_data_q;
      fault_d    = fault_q;
      timeout_d  = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               type_d     = type_;
               unsigned_d = unsigned_;
               off_d      = addr[1:0];
               mem_addr_d = {addr[31:2], 2'b00};
               if (misaligned) begin
                  state_d   = S_DONE;
                  fault_d   = 1'b1;
                  timeout_d = 1'b0;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            // Acceptance is not completion, so expiry in REQ always aborts.
            if (expired) begin
               state_d   = S_DONE;
               fault_d   = 1'b1;
               timeout_d = 1'b1;
            end else if (mem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d   = S_DONE;
               rd_data_d = load_data;
               fault_d   = 1'b0;
               timeout_d = 1'b0;
            end else if (expired) begin
               state_d   = S_DONE;
               fault_d   = 1'b1;
               timeout_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         type_q     <= 2'b00;
         unsigned_q <= 1'b0;
         off_q      <= 2'b00;
         mem_addr_q <= '0;
         rd_data_q  <= '0;
         fault_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         unsigned_q <= unsigned_d;
         off_q      <= off_d;
         mem_addr_q <= mem_addr_d;
         rd_data_q  <= rd_data_d;
         fault_q    <= fault_d;
         timeout_q  <= timeout_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign mem_req  = (state_q == S_REQ);
   assign mem_addr = mem_addr_q;
   assign rd_data  = rd_data_q;
   assign fault    = fault_q;
   assign timeout  = timeout_q;

endmodule
